// File: rtl/conv_batch_ctrl.sv
// Batch float16->int16 conversion controller: reads operand pairs from byte memory, runs the external converter, writes results back.
// Latency: 5 cycles per element when the converter acks in its first request cycle, plus 1 DONE cycle per batch.
// Backpressure: stalls in CONV until cv_ack, or gives up after ACK_TIMEOUT cycles; start is ignored while busy.
module conv_batch_ctrl #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  src_base,
  input  logic [7:0]  dst_base,
  input  logic [5:0]  count,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  sat_cnt,
  output logic [7:0]  dm_addr,
  output logic        dm_wr_en,
  output logic [7:0]  dm_din,
  input  logic [7:0]  dm_dout,
  output logic        cv_req,
  output logic [15:0] cv_operand,
  input  logic        cv_ack,
  input  logic [15:0] cv_result
);

  // Timeout counter runs 0..ACK_TIMEOUT-1 while in CONV.
  localparam int TMO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    CONV  = 3'd3,
    WR_LO = 3'd4,
    WR_HI = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t           r_state;
  logic [7:0]       r_src;
  logic [7:0]       r_dst;
  logic [5:0]       r_cnt;
  logic [5:0]       r_i;
  logic [TMO_W-1:0] r_tmo;
  logic [15:0]      r_operand;
  logic [15:0]      r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [5:0]       r_sat_cnt;
  logic [7:0]       r_dm_addr;
  logic             r_dm_wr_en;
  logic             r_cv_req;

  logic [5:0]       w_i_nxt;
  logic [7:0]       w_src_addr;
  logic [7:0]       w_src_nxt;
  logic [7:0]       w_dst_addr;
  logic             w_tmo_hit;
  logic [15:0]      w_cap;
  logic             w_sat_hit;

  // Element addresses; all byte arithmetic wraps modulo 256 on purpose.
  assign w_i_nxt    = r_i + 6'd1;
  assign w_src_addr = r_src + {1'b0, r_i, 1'b0};
  assign w_src_nxt  = r_src + {1'b0, w_i_nxt, 1'b0};
  assign w_dst_addr = r_dst + {1'b0, r_i, 1'b0};

  // Value captured on leaving CONV: converter result, or the negative
  // saturation code when the converter never answered.
  assign w_tmo_hit  = (r_tmo == TMO_LAST);
  assign w_cap      = cv_ack ? cv_result : 16'h8000;
  assign w_sat_hit  = (w_cap == 16'h7FFF) || (w_cap == 16'h8000);

  // Batch sequencer; every control output is registered on the transition into the state that needs it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_src      <= 8'd0;
      r_dst      <= 8'd0;
      r_cnt      <= 6'd0;
      r_i        <= 6'd0;
      r_tmo      <= '0;
      r_operand  <= 16'd0;
      r_result   <= 16'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_sat_cnt  <= 6'd0;
      r_dm_addr  <= 8'd0;
      r_dm_wr_en <= 1'b0;
      r_cv_req   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_src     <= src_base;
            r_dst     <= dst_base;
            r_cnt     <= count;
            r_i       <= 6'd0;
            r_err     <= 1'b0;
            r_sat_cnt <= 6'd0;
            r_dm_addr <= src_base;
            r_busy    <= 1'b1;
            r_state   <= RD_LO;
          end
        end

        RD_LO: begin
          // An empty batch passes through RD_LO once and finishes without touching memory.
          if (r_cnt == 6'd0) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_operand[7:0] <= dm_dout;
            r_dm_addr      <= w_src_addr + 8'd1;
            r_state        <= RD_HI;
          end
        end

        RD_HI: begin
          r_operand[15:8] <= dm_dout;
          r_tmo           <= '0;
          r_cv_req        <= 1'b1;
          r_state         <= CONV;
        end

        CONV: begin
          if (cv_ack || w_tmo_hit) begin
            r_result   <= w_cap;
            r_cv_req   <= 1'b0;
            r_dm_addr  <= w_dst_addr;
            r_dm_wr_en <= 1'b1;
            r_state    <= WR_LO;
            if (!cv_ack) begin
              r_err <= 1'b1;
            end
            if (w_sat_hit && (r_sat_cnt != 6'd63)) begin
              r_sat_cnt <= r_sat_cnt + 6'd1;
            end
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        WR_LO: begin
          r_dm_addr <= w_dst_addr + 8'd1;
          r_state   <= WR_HI;
        end

        WR_HI: begin
          r_dm_wr_en <= 1'b0;
          r_i        <= w_i_nxt;
          if (w_i_nxt == r_cnt) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_dm_addr <= w_src_nxt;
            r_state   <= RD_LO;
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_dm_wr_en <= 1'b0;
          r_cv_req   <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign sat_cnt    = r_sat_cnt;
  assign dm_addr    = r_dm_addr;
  assign dm_wr_en   = r_dm_wr_en;
  assign cv_req     = r_cv_req;
  assign cv_operand = r_operand;
  // Write data follows the byte lane selected by the write state.
  assign dm_din     = (r_state == WR_HI) ? r_result[15:8] : r_result[7:0];

endmodule

// File: doc/conv_batch_ctrl.md
CONV_BATCH_CTRL -- requirements
Module: conv_batch_ctrl

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 64, giving the maximum cycles to wait for cv_ack before aborting an element.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning), clock and reset first:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle batch request.
- src_base  in  8  byte address of the first source float.
- dst_base  in  8  byte address of the first destination integer.
- count  in  6  number of 16-bit elements in the batch.
- busy  out  1  high while a batch is in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky; set if any element timed out.
- sat_cnt  out  6  count of results equal to 16'h7FFF or 16'h8000.
- dm_addr  out  8  data memory byte address.
- dm_wr_en  out  1  data memory write strobe.
- dm_din  out  8  write data to data memory.
- dm_dout  in  8  read data from data memory; combinational, valid in the cycle dm_addr is presented.
- cv_req  out  1  converter request.
- cv_operand  out  16  float16 operand to the converter.
- cv_ack  in  1  converter acknowledge; cv_result is valid when cv_ack is high.
- cv_result  in  16  two's-complement integer result.

Function
REQ-003 The controller SHALL be an FSM with states IDLE, RD_LO, RD_HI, CONV, WR_LO, WR_HI and DONE.
REQ-004 When start is sampled high in IDLE, the controller SHALL latch src_base, dst_base and count, clear index i, err and sat_cnt, and go to RD_LO; if the latched count is 0 it SHALL go directly to DONE.
REQ-005 The controller SHALL ignore start in every state other than IDLE.
REQ-006 In RD_LO, dm_addr SHALL be src+2i and dm_dout SHALL be captured into operand[7:0]; in RD_HI, dm_addr SHALL be src+2i+1 and dm_dout SHALL be captured into operand[15:8] (little-endian).
REQ-007 In CONV:
- cv_req SHALL be high and cv_operand SHALL hold the operand.
- On the cycle cv_ack is high, cv_result SHALL be captured and the state SHALL move to WR_LO.
- cv_req SHALL drop in the cycle after ack.
REQ-008 If cv_ack is not seen within ACK_TIMEOUT cycles of entering CONV, the controller SHALL set err, capture result 16'h8000, and go to WR_LO.
REQ-009 In WR_LO the block SHALL drive dm_addr=dst+2i, dm_din=result[7:0] and dm_wr_en=1; in WR_HI it SHALL drive dm_addr=dst+2i+1, dm_din=result[15:8] and dm_wr_en=1.
REQ-010 On leaving WR_HI, i SHALL increment; if i+1==count the state SHALL be DONE, otherwise RD_LO.
REQ-011 All address arithmetic SHALL be 8-bit, modulo 256; a wrap past 8'hFF SHALL continue at 8'h00 with no flag.
REQ-012 sat_cnt SHALL increment when a captured result (including a timeout value) equals 16'h7FFF or 16'h8000, and SHALL saturate at 63.
REQ-013 In DONE, done SHALL be high for exactly one cycle, after which the state SHALL return to IDLE.
REQ-014 busy SHALL be high in every state except IDLE.
REQ-015 dm_wr_en SHALL be high only in WR_LO and WR_HI; cv_req SHALL be high only in CONV.
REQ-016 Outputs other than dm_din and cv_operand SHALL be registered or decoded from state only; no combinational path from cv_ack to cv_req is allowed.
REQ-017 Minimum latency per element SHALL be 5 cycles (ack in the first CONV cycle); done SHALL rise 6 cycles after start is sampled for count=1.
REQ-018 A source/destination overlap SHALL be handled in element order, with no hazard protection: element i is read before element i is written.

Reset
REQ-019 Reset SHALL return the FSM to IDLE and force busy=0, done=0, err=0, sat_cnt=0, dm_wr_en=0, cv_req=0, dm_addr=0 and i=0.
REQ-020 Reset asserted mid-batch SHALL abort the batch on the next edge with no further memory writes and no done pulse; partially written elements remain in memory.
REQ-021 Reset SHALL take priority over start in the same cycle.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single element: mem[4]=8'h00, mem[5]=8'h3C, src=4, dst=6, count=1; converter acks immediately with 16'h0001 -> mem[6]=8'h01, mem[7]=8'h00, done 6 cycles after start, sat_cnt=0, err=0.
- Batch: count=3, src=8'h10, dst=8'h20, converter ack delayed 3 cycles -> 6 writes at 8'h20..8'h25 in order; done after 3x7+1 cycles; busy high throughout.
- Saturation and timeout: results 16'h7FFF then 16'h8000, then a third element never acked -> sat_cnt=3, err=1, third result written as 8'h00/8'h80 after ACK_TIMEOUT cycles.
- Edge cases: count=0 -> done 2 cycles after start with no memory traffic; start while busy -> ignored; src=8'hFF -> high byte read from 8'h00.
- Reset mid-batch: reset during CONV of element 2 of 4 -> busy=0 next cycle, no done, only element 1 written; a new start afterwards runs normally.
